// File: rtl/acc_arb_pkg.sv
// Shared types and defaults for the divider-accelerator arbiter.
package acc_arb_pkg;

   localparam int IN_BYTES_DEF  = 4;
   localparam int OUT_BYTES_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a pointer that hands priority to the
// requester that was not just served.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   input  logic       served_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) ptr_d = ~served_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end

   // A lone request wins outright; the pointer only breaks ties.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/acc_dvd_arbiter.sv
// Shares one byte-serial divider accelerator between two requesters:
// grant, clear the accelerator, stream operands in, wait, stream results out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner; grant on any request
// CLR      | one-cycle accelerator reset for the new owner
// LOAD     | forward owner's operand bytes until IN_BYTES accepted
// WAIT     | accelerator computing; leave once its output buffer fills
// DRAIN    | forward owner's result pops until OUT_BYTES popped
module acc_dvd_arbiter
   import acc_arb_pkg::*;
#(
   parameter int IN_BYTES  = IN_BYTES_DEF,
   parameter int OUT_BYTES = OUT_BYTES_DEF
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic [1:0] Req,
   output logic [1:0] Gnt,
   input  logic [1:0] StartData,
   input  logic [7:0] BusDataIn0,
   input  logic [7:0] BusDataIn1,
   input  logic [1:0] ReceiveData,
   output logic [1:0] ReadyToAccept,
   output logic [1:0] OutBuffFull,
   output logic [7:0] BusDataOut,
   input  logic       AccReadyToAccept,
   input  logic       AccOutBuffFull,
   input  logic [7:0] AccBusDataOut,
   output logic       AccRst,
   output logic       AccStartData,
   output logic       AccReceiveData,
   output logic [7:0] AccBusDataIn,
   output logic       Busy
);

   localparam int MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
   localparam int CW        = $clog2(MAX_BYTES) + 1;
   localparam logic [CW-1:0] IN_LAST  = CW'(IN_BYTES - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BYTES - 1);

   state_t          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [1:0]      arb_gnt;
   logic            arb_adv;
   logic            g;
   logic            acc_start;
   logic            acc_recv;
   logic            in_load;
   logic            in_drain;

   assign g = gnt_q[1];

   rr_arb2 u_rr_arb2 (
      .clk_i    (clk),
      .rst_i    (Rst),
      .req_i    (Req),
      .adv_i    (arb_adv),
      .served_i (g),
      .gnt_o    (arb_gnt)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      arb_adv   = 1'b0;
      acc_start = 1'b0;
      acc_recv  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|Req) begin
               gnt_d     = arb_gnt;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               state_d   = ST_CLR;
            end
         end
         ST_CLR: state_d = ST_LOAD;
         ST_LOAD: begin
            acc_start = StartData[g] & AccReadyToAccept;
            if (acc_start) begin
               in_cnt_d = in_cnt_q + CW'(1);
               if (in_cnt_q == IN_LAST) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (AccOutBuffFull) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            acc_recv = ReceiveData[g] & AccOutBuffFull;
            if (acc_recv) begin
               out_cnt_d = out_cnt_q + CW'(1);
               if (out_cnt_q == OUT_LAST) begin
                  gnt_d   = 2'b00;
                  arb_adv = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset wins combinationally too, so no strobe leaks in the reset cycle.
      if (Rst) begin
         acc_start = 1'b0;
         acc_recv  = 1'b0;
         arb_adv   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 2'b00;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign in_load  = (state_q == ST_LOAD)  && !Rst;
   assign in_drain = (state_q == ST_DRAIN) && !Rst;

   assign Gnt            = gnt_q;
   assign Busy           = (state_q != ST_IDLE) && !Rst;
   assign AccRst         = Rst || (state_q == ST_CLR);
   assign AccStartData   = acc_start;
   assign AccReceiveData = acc_recv;
   assign AccBusDataIn   = in_load  ? (g ? BusDataIn1 : BusDataIn0) : 8'h00;
   assign BusDataOut     = in_drain ? AccBusDataOut : 8'h00;

   assign ReadyToAccept = in_load  ? (g ? {AccReadyToAccept, 1'b0} : {1'b0, AccReadyToAccept})
                                   : 2'b00;
   assign OutBuffFull   = in_drain ? (g ? {AccOutBuffFull, 1'b0}   : {1'b0, AccOutBuffFull})
                                   : 2'b00;

endmodule

// File: tb/tb_acc_dvd_arbiter.sv
// Bench for acc_dvd_arbiter: behavioural 16/16 divider accelerator plus two
// requesters driven from one process; results checked against a / b, a % b.
module tb_acc_dvd_arbiter;

   logic       clk = 1'b0;
   logic       Rst;
   logic [1:0] Req, Gnt, StartData, ReceiveData, ReadyToAccept, OutBuffFull;
   logic [7:0] BusDataIn0, BusDataIn1, BusDataOut, AccBusDataOut, AccBusDataIn;
   logic       AccReadyToAccept, AccOutBuffFull, AccRst, AccStartData, AccReceiveData, Busy;

   always #5 clk = ~clk;

   acc_dvd_arbiter #(.IN_BYTES(4), .OUT_BYTES(4)) dut (
      .clk              (clk),
      .Rst              (Rst),
      .Req              (Req),
      .Gnt              (Gnt),
      .StartData        (StartData),
      .BusDataIn0       (BusDataIn0),
      .BusDataIn1       (BusDataIn1),
      .ReceiveData      (ReceiveData),
      .ReadyToAccept    (ReadyToAccept),
      .OutBuffFull      (OutBuffFull),
      .BusDataOut       (BusDataOut),
      .AccReadyToAccept (AccReadyToAccept),
      .AccOutBuffFull   (AccOutBuffFull),
      .AccBusDataOut    (AccBusDataOut),
      .AccRst           (AccRst),
      .AccStartData     (AccStartData),
      .AccReceiveData   (AccReceiveData),
      .AccBusDataIn     (AccBusDataIn),
      .Busy             (Busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int ptr_model = 0;

   // accelerator model: 4 operand bytes (dividend, divisor, MSB first) in,
   // 4 result bytes (quotient, remainder) out after a short latency
   logic [7:0]  acc_in [4] = '{default: 8'h00};
   int          acc_icnt = 0, acc_ocnt = 0, acc_lat = 0;
   logic        acc_full = 1'b0;
   logic        bp_mode = 1'b0, rdy_rand = 1'b1, rdy_force_low = 1'b0;
   int          n_start = 0, n_recv = 0, n_accrst = 0;
   logic [15:0] acc_dvd, acc_dvs, acc_q, acc_r;

   assign AccReadyToAccept = rdy_rand && !rdy_force_low && (acc_icnt < 4);
   assign AccOutBuffFull   = acc_full;

   always_comb begin
      acc_dvd = {acc_in[0], acc_in[1]};
      acc_dvs = {acc_in[2], acc_in[3]};
      acc_q   = 16'hFFFF;
      acc_r   = acc_dvd;
      if (acc_dvs != 16'd0) begin
         acc_q = acc_dvd / acc_dvs;
         acc_r = acc_dvd % acc_dvs;
      end
      case (acc_ocnt)
         0:       AccBusDataOut = acc_q[15:8];
         1:       AccBusDataOut = acc_q[7:0];
         2:       AccBusDataOut = acc_r[15:8];
         3:       AccBusDataOut = acc_r[7:0];
         default: AccBusDataOut = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (AccStartData)   n_start  <= n_start + 1;
      if (AccReceiveData) n_recv   <= n_recv + 1;
      if (AccRst)         n_accrst <= n_accrst + 1;
      if (AccRst) begin
         acc_icnt <= 0;
         acc_ocnt <= 0;
         acc_lat  <= 0;
         acc_full <= 1'b0;
      end else begin
         if (AccStartData && acc_icnt < 4) begin
            acc_in[acc_icnt[1:0]] <= AccBusDataIn;
            acc_icnt <= acc_icnt + 1;
            if (acc_icnt == 3) acc_lat <= 3;
         end else if (acc_lat > 1) begin
            acc_lat <= acc_lat - 1;
         end else if (acc_lat == 1) begin
            acc_lat  <= 0;
            acc_full <= 1'b1;
         end
         if (AccReceiveData && acc_full) begin
            acc_ocnt <= acc_ocnt + 1;
            if (acc_ocnt == 3) acc_full <= 1'b0;
         end
      end
   end

   always @(negedge clk) rdy_rand <= bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_gnt(input int r);
      int n = 0;
      while (Gnt == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("gnt", 32'(Gnt), (r == 0) ? 32'd1 : 32'd2);
      chk("clr_accrst", 32'(AccRst), 32'd1);
   endtask

   task automatic send_bytes(input int r, input logic [15:0] a, input logic [15:0] b, input bit drop);
      logic [7:0] bytes [4];
      int i = 0;
      int n = 0;
      bit stb, acc;
      bytes[0] = a[15:8];
      bytes[1] = a[7:0];
      bytes[2] = b[15:8];
      bytes[3] = b[7:0];
      while (i < 4 && n < 300) begin
         @(negedge clk);
         if (drop && i == 1) Req[r] = 1'b0;
         stb = ($urandom_range(0, 3) != 0);
         StartData[r] = stb;
         if (r == 0) BusDataIn0 = bytes[i];
         else        BusDataIn1 = bytes[i];
         #1;
         acc = stb && AccReadyToAccept;
         chk("rta", 32'(ReadyToAccept),
             (r == 0) ? {31'd0, AccReadyToAccept} : {30'd0, AccReadyToAccept, 1'b0});
         chk("acc_start", 32'(AccStartData), 32'(acc));
         if (acc) chk("acc_din", 32'(AccBusDataIn), 32'(bytes[i]));
         @(posedge clk);
         if (acc) i++;
         n++;
      end
      chk("send_done", i, 4);
   endtask

   task automatic recv_bytes(input int r, output logic [31:0] res);
      int i = 0;
      int n = 0;
      bit stb, pop, drain;
      bit seen = 1'b0;
      res = '0;
      while (i < 4 && n < 300) begin
         @(negedge clk);
         StartData[r] = 1'b0;
         stb = ($urandom_range(0, 2) != 0);
         ReceiveData[r] = stb;
         #1;
         // the arbiter leaves WAIT one cycle after it first sees the buffer full
         drain = seen && AccOutBuffFull;
         seen  = seen || AccOutBuffFull;
         pop   = stb && drain;
         chk("obf", 32'(OutBuffFull), drain ? ((r == 0) ? 32'd1 : 32'd2) : 32'd0);
         chk("acc_recv", 32'(AccReceiveData), 32'(pop));
         if (pop) res[31-8*i -: 8] = BusDataOut;
         @(posedge clk);
         if (pop) i++;
         n++;
      end
      @(negedge clk);
      ReceiveData[r] = 1'b0;
      chk("recv_done", i, 4);
   endtask

   task automatic do_txn(input int r, input logic [15:0] a, input logic [15:0] b,
                         input bit drop_load, input int bp);
      int s0, r0, c0;
      logic [31:0] res;
      s0 = n_start;
      r0 = n_recv;
      c0 = n_accrst;
      wait_gnt(r);
      if (!drop_load) Req[r] = 1'b0;
      if (bp > 0) begin
         rdy_force_low = 1'b1;
         for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            StartData[r] = 1'b1;
            if (r == 0) BusDataIn0 = 8'h5A;
            else        BusDataIn1 = 8'h5A;
            #1;
            chk("bp_rta", 32'(ReadyToAccept), 32'd0);
            chk("bp_start", 32'(AccStartData), 32'd0);
         end
         @(negedge clk);
         StartData[r]  = 1'b0;
         rdy_force_low = 1'b0;
         chk("bp_nostart", n_start - s0, 0);
      end
      send_bytes(r, a, b, drop_load);
      recv_bytes(r, res);
      chk("quot", {16'd0, res[31:16]}, {16'd0, a / b});
      chk("rem", {16'd0, res[15:0]}, {16'd0, a % b});
      chk("gnt_clear", 32'(Gnt), 32'd0);
      chk("start_cnt", n_start - s0, 4);
      chk("recv_cnt", n_recv - r0, 4);
      chk("accrst_pulses", n_accrst - c0, 1);
      ptr_model = 1 - r;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
      $fatal(1, "time limit");
   end

   initial begin
      int w, sel;
      logic [15:0] ra, rb, rc, rd;
      bit drop;
      Rst = 1'b1;
      Req = 2'b00;
      StartData = 2'b00;
      ReceiveData = 2'b00;
      BusDataIn0 = 8'h00;
      BusDataIn1 = 8'h00;

      repeat (2) @(negedge clk);
      Req = 2'b11;
      StartData = 2'b11;
      ReceiveData = 2'b11;
      #1;
      chk("rst_gnt", 32'(Gnt), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_accrst", 32'(AccRst), 32'd1);
      chk("rst_start", 32'(AccStartData), 32'd0);
      chk("rst_recv", 32'(AccReceiveData), 32'd0);
      chk("rst_rta", 32'(ReadyToAccept), 32'd0);
      chk("rst_obf", 32'(OutBuffFull), 32'd0);
      chk("rst_bdo", 32'(BusDataOut), 32'd0);
      chk("rst_abdi", 32'(AccBusDataIn), 32'd0);
      @(negedge clk);
      chk("rst_gnt_held", 32'(Gnt), 32'd0);
      StartData = 2'b00;
      ReceiveData = 2'b00;
      Rst = 1'b0;
      ptr_model = 0;

      // simultaneous from reset: 0 first, then 1 after a single idle cycle
      do_txn(0, 16'd300, 16'd7, 1'b0, 0);
      @(negedge clk);
      chk("b2b_busy", 32'(Busy), 32'd1);
      chk("b2b_gnt", 32'(Gnt), 32'd2);
      do_txn(1, 16'd65535, 16'd255, 1'b0, 0);

      // single requester, 100 / 7
      Req = 2'b01;
      do_txn(0, 16'd100, 16'd7, 1'b0, 0);

      // pointer now favours requester 1
      Req = 2'b11;
      do_txn(1, 16'd4321, 16'd12, 1'b1, 0);
      @(negedge clk);
      chk("b2b_gnt_ptr1", 32'(Gnt), 32'd1);
      do_txn(0, 16'd999, 16'd1000, 1'b0, 0);

      // lone request for 0 despite pointer, stray strobes from 1, Req dropped in LOAD
      StartData[1] = 1'b1;
      ReceiveData[1] = 1'b1;
      BusDataIn1 = 8'hA5;
      Req = 2'b01;
      do_txn(0, 16'd5000, 16'd3, 1'b1, 0);
      StartData[1] = 1'b0;
      ReceiveData[1] = 1'b0;

      // accelerator backpressure for 3 cycles in LOAD
      Req = 2'b01;
      do_txn(0, 16'd12345, 16'd67, 1'b0, 3);

      // reset while waiting on the accelerator
      Req = 2'b01;
      wait_gnt(0);
      Req = 2'b00;
      send_bytes(0, 16'd40, 16'd3, 1'b0);
      @(negedge clk);
      chk("wait_busy", 32'(Busy), 32'd1);
      chk("wait_obf", 32'(OutBuffFull), 32'd0);
      Rst = 1'b1;
      #1;
      chk("wrst_accrst", 32'(AccRst), 32'd1);
      chk("wrst_busy", 32'(Busy), 32'd0);
      @(negedge clk);
      chk("wrst_gnt", 32'(Gnt), 32'd0);
      chk("wrst_busy2", 32'(Busy), 32'd0);
      chk("wrst_accrst2", 32'(AccRst), 32'd1);
      Rst = 1'b0;
      ptr_model = 0;
      Req = 2'b11;
      do_txn(0, 16'd1000, 16'd10, 1'b0, 0);
      @(negedge clk);
      chk("wrst_b2b_gnt", 32'(Gnt), 32'd2);
      do_txn(1, 16'd77, 16'd5, 1'b0, 0);

      // randomized traffic with random accelerator backpressure
      bp_mode = 1'b1;
      for (int t = 0; t < 12; t++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom_range(1, 600));
         rc   = 16'($urandom);
         rd   = 16'($urandom_range(1, 65535));
         drop = 1'($urandom_range(0, 1));
         sel  = $urandom_range(0, 2);
         if (sel == 2) begin
            Req = 2'b11;
            w = ptr_model;
            do_txn(w, ra, rb, drop, 0);
            @(negedge clk);
            chk("rnd_b2b_gnt", 32'(Gnt), (w == 0) ? 32'd2 : 32'd1);
            do_txn(1 - w, rc, rd, !drop, 0);
         end else begin
            Req[sel] = 1'b1;
            do_txn(sel, ra, rb, drop, 0);
         end
      end
      bp_mode = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/acc_dvd_arbiter.md
ACC_DVD_ARBITER -- requirements
Module: acc_dvd_arbiter

Interface
REQ-001 SHALL have parameter IN_BYTES, default 4, input bytes per transaction.
REQ-002 SHALL have parameter OUT_BYTES, default 4, result bytes per transaction.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port Req, input, 2, per-requester request for the accelerator.
REQ-007 SHALL have port Gnt, output, 2, one-hot grant, zero when idle.
REQ-008 SHALL have port StartData, input, 2, per-requester input-byte strobe.
REQ-009 SHALL have ports BusDataIn0 and BusDataIn1, input, 8, per-requester input byte.
REQ-010 SHALL have port ReceiveData, input, 2, per-requester result-byte pop.
REQ-011 SHALL have ports ReadyToAccept and OutBuffFull, output, 2 each, per-requester status.
REQ-012 SHALL have port BusDataOut, output, 8, result byte, shared by both requesters.
REQ-013 SHALL have ports AccReadyToAccept and AccOutBuffFull, input, 1 each, and AccBusDataOut, input, 8, all from the accelerator.
REQ-014 SHALL have ports AccRst, AccStartData and AccReceiveData, output, 1 each, and AccBusDataIn, output, 8, all to the accelerator.
REQ-015 SHALL have port Busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL use states IDLE, CLR, LOAD, WAIT and DRAIN.
REQ-017 IDLE: when any Req bit is high, SHALL grant by round-robin, register Gnt, and go to CLR next cycle.
REQ-018 Round-robin: pointer resets to 0; on simultaneous requests, the pointer's requester wins; the pointer moves to the other requester when DRAIN completes.
REQ-019 A single active request SHALL be granted regardless of the pointer.
REQ-020 CLR SHALL last exactly one cycle with AccRst=1, then go to LOAD.
REQ-021 AccRst SHALL equal Rst OR (state==CLR).
REQ-022 LOAD: AccStartData SHALL equal StartData[g] AND AccReadyToAccept, and AccBusDataIn SHALL equal BusDataIn of granted requester g, combinationally.
REQ-023 LOAD: each accepted byte SHALL increment in_cnt; on the IN_BYTES-th accept, SHALL go to WAIT.
REQ-024 WAIT: SHALL go to DRAIN on the first cycle with AccOutBuffFull=1.
REQ-025 DRAIN: AccReceiveData SHALL equal ReceiveData[g] AND AccOutBuffFull, and BusDataOut SHALL equal AccBusDataOut.
REQ-026 DRAIN: each pop SHALL increment out_cnt; on the OUT_BYTES-th pop, SHALL clear Gnt, update the pointer and go to IDLE.
REQ-027 ReadyToAccept[g] SHALL be AccReadyToAccept only in LOAD; OutBuffFull[g] SHALL be AccOutBuffFull only in DRAIN; the non-granted bits and all bits in other states SHALL be 0.
REQ-028 StartData and ReceiveData from the non-granted requester SHALL be ignored, never forwarded.
REQ-029 Req deasserting after grant SHALL be ignored; the transaction SHALL run to completion.
REQ-030 Counters SHALL be $clog2(max(IN_BYTES,OUT_BYTES))+1 bits wide, clear on entry to CLR, and never wrap.
REQ-031 Back-to-back: a request pending at DRAIN completion SHALL be granted in the following IDLE cycle, so IDLE lasts 1 cycle.

Reset
REQ-032 On Rst in any state: state=IDLE, Gnt=0, pointer=0, counters=0, Busy=0, AccRst=1.
REQ-033 During reset: AccStartData=0, AccReceiveData=0, ReadyToAccept=0, OutBuffFull=0, BusDataOut=0, AccBusDataIn=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction without forwarding any further strobes.

Structure
REQ-035 Package acc_arb_pkg SHALL hold the state enum typedef and the IN_BYTES and OUT_BYTES defaults.
REQ-036 SHALL contain one sub-module, rr_arb2 (2-way round-robin grant and pointer); the FSM, counters and muxing stay in the top level.

Verification
REQ-037 Single requester: Req=01, send bytes 00,64,00,07 (100/7) -> Gnt=01, one AccRst pulse, popped bytes give Q=14 and R=2, then Gnt=00.
REQ-038 Simultaneous: Req=11 from reset -> requester 0 served first, then requester 1 with exactly 1 IDLE cycle between transactions.
REQ-039 Stray strobes: requester 1 pulses StartData and ReceiveData while requester 0 holds the grant -> no AccStartData or AccReceiveData pulses, in_cnt unchanged.
REQ-040 Backpressure: AccReadyToAccept low for 3 cycles in LOAD -> no accept, no count change, and the transaction completes correctly afterwards.
REQ-041 Rst asserted in WAIT -> next cycle IDLE, Gnt=00, AccRst=1, and a new request completes 1000/10 -> Q=100, R=0.
REQ-042 Req dropped during LOAD -> grant held and the transaction completes.
